// File: rtl/pipe_hazard_unit.sv
// pipe_hazard_unit: load-use stall, branch flush and operand forwarding for a 5-stage pipeline
module pipe_hazard_unit #(
    parameter int REG_AW  = 5,
    parameter int NUM_SRC = 2,
    parameter int CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      id_valid,
    input  logic [NUM_SRC*REG_AW-1:0] id_rs,
    input  logic [NUM_SRC-1:0]        id_rs_used,
    input  logic [REG_AW-1:0]         id_rd,
    input  logic                      id_regwrite,
    input  logic                      id_memread,
    input  logic                      br_taken,
    output logic                      stall,
    output logic                      flush,
    output logic [NUM_SRC*2-1:0]      fwd_sel,
    output logic [CNT_W-1:0]          stall_cnt,
    output logic [CNT_W-1:0]          flush_cnt
);
    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    logic              r_ex_v, r_ex_rw, r_ex_mr;
    logic [REG_AW-1:0] r_ex_rd;
    logic              r_mem_v, r_mem_rw, r_mem_mr;
    logic [REG_AW-1:0] r_mem_rd;
    logic              r_wb_v, r_wb_rw;
    logic [REG_AW-1:0] r_wb_rd;
    logic [CNT_W-1:0]  r_stall_cnt, r_flush_cnt;
    logic [NUM_SRC-1:0] w_lu;
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        logic [REG_AW-1:0] w_rs;
        logic              w_ok, w_ex, w_mem, w_wb;
        assign w_rs  = id_rs[i*REG_AW +: REG_AW];
        assign w_ok  = id_rs_used[i] && (w_rs != '0);
        assign w_ex  = w_ok && r_ex_v && r_ex_rw && (r_ex_rd == w_rs);
        assign w_mem = w_ok && r_mem_v && r_mem_rw && (r_mem_rd == w_rs);
        assign w_wb  = w_ok && r_wb_v && r_wb_rw && (r_wb_rd == w_rs);
        assign w_lu[i] = w_ex && r_ex_mr;
        assign fwd_sel[2*i +: 2] = stall ? 2'd0 : w_ex ? 2'd1 : w_mem ? 2'd2 : w_wb ? 2'd3 : 2'd0;
    end
    assign flush     = br_taken;
    assign stall     = id_valid && (|w_lu) && !br_taken;
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
    // shadow pipeline: WB always takes old MEM; flush bubbles EX and MEM, stall bubbles EX
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ex_v   <= 1'b0;
            r_ex_rw  <= 1'b0;
            r_ex_mr  <= 1'b0;
            r_ex_rd  <= '0;
            r_mem_v  <= 1'b0;
            r_mem_rw <= 1'b0;
            r_mem_mr <= 1'b0;
            r_mem_rd <= '0;
            r_wb_v   <= 1'b0;
            r_wb_rw  <= 1'b0;
            r_wb_rd  <= '0;
        end else begin
            r_wb_v   <= r_mem_v;
            r_wb_rw  <= r_mem_rw;
            r_wb_rd  <= r_mem_rd;
            r_mem_v  <= r_ex_v && !flush;
            r_mem_rw <= r_ex_rw;
            r_mem_mr <= r_ex_mr;
            r_mem_rd <= r_ex_rd;
            r_ex_v   <= id_valid && !flush && !stall;
            r_ex_rw  <= id_regwrite;
            r_ex_mr  <= id_memread;
            r_ex_rd  <= id_rd;
        end
    end
    // saturating stall and flush event counters
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_ONE;
            if (flush && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + CNT_ONE;
        end
    end
endmodule

// File: doc/pipe_hazard_unit.md
PIPE_HAZARD_UNIT -- requirements
Module: pipe_hazard_unit

Interface
REQ-001 SHALL have parameter REG_AW, default 5, register-address width.
REQ-002 SHALL have parameter NUM_SRC, default 2, legal 1..4, source operands per instruction.
REQ-003 SHALL have parameter CNT_W, default 16, performance-counter width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port id_valid  input  1  an instruction occupies ID this cycle.
REQ-007 SHALL have port id_rs  input  NUM_SRC*REG_AW  source register numbers; src i at [i*REG_AW +: REG_AW].
REQ-008 SHALL have port id_rs_used  input  NUM_SRC  bit i set when src i is actually read.
REQ-009 SHALL have port id_rd  input  REG_AW  destination register of the ID instruction.
REQ-010 SHALL have port id_regwrite  input  1  ID instruction writes id_rd.
REQ-011 SHALL have port id_memread  input  1  ID instruction is a load.
REQ-012 SHALL have port br_taken  input  1  branch resolved taken in MEM this cycle.
REQ-013 SHALL have port stall  output  1  hold PC and IF/ID; insert bubble into ID/EX.
REQ-014 SHALL have port flush  output  1  squash IF/ID, ID/EX, EX/MEM contents at next edge.
REQ-015 SHALL have port fwd_sel  output  NUM_SRC*2  per-source select: 0 regfile, 1 from EX producer, 2 from MEM producer, 3 from WB producer.
REQ-016 SHALL have port stall_cnt  output  CNT_W  saturating count of stall cycles.
REQ-017 SHALL have port flush_cnt  output  CNT_W  saturating count of flush events.

Function
REQ-018 SHALL keep a 3-entry shadow pipeline EX, MEM, WB; each entry holds {valid, rd, regwrite, memread}.
REQ-019 SHALL, each edge without flush or stall, shift ID->EX->MEM->WB; ID fields enter EX only if id_valid.
REQ-020 SHALL, on stall without flush, load a bubble (valid=0) into EX while MEM and WB still advance.
REQ-021 SHALL, on flush, clear EX and MEM entries to bubbles and advance old MEM into WB.
REQ-022 SHALL treat a stage as a producer for src i only if valid, regwrite, rd==rs_i, rs_i!=0 and id_rs_used[i].
REQ-023 SHALL select fwd_sel combinationally with youngest-producer priority: EX (1) over MEM (2) over WB (3) over regfile (0).
REQ-024 SHALL assert stall combinationally when id_valid and any used source matches an EX producer with memread=1 (load-use).
REQ-025 SHALL drive fwd_sel=0 for every source while stall is asserted.
REQ-026 SHALL assert flush combinationally in the same cycle br_taken is high; one cycle per br_taken pulse.
REQ-027 SHALL give flush priority over stall: when both conditions hold, stall=0, flush=1.
REQ-028 SHALL never let register 0 cause forwarding or stall, regardless of regwrite.
REQ-029 SHALL increment stall_cnt each cycle stall=1 and flush_cnt each cycle flush=1; both saturate at 2^CNT_W-1, no wrap.
REQ-030 SHALL have zero-cycle combinational latency from inputs to stall, flush, fwd_sel; state effect visible next edge.

Reset
REQ-031 SHALL, on reset high at an edge, clear all shadow entries to valid=0 and both counters to 0, overriding shift, stall and flush.
REQ-032 SHALL, while reset is high, see stall and flush depend only on inputs and cleared state (no producer matches), so stall=0 unless br_taken drives flush.
REQ-033 SHALL, on reset mid-operation, discard all in-flight producers; first post-reset cycle has fwd_sel=0 for all sources.

Verification
REQ-034 SHALL pass: issue add r3 then sub using r3 next cycle -> fwd_sel src0=1, stall=0; one cycle later an independent instruction reading r3 -> fwd_sel=2.
REQ-035 SHALL pass: issue lw r5 then add reading r5 -> stall=1 for exactly one cycle, stall_cnt=1, then fwd_sel=2 on the retried add.
REQ-036 SHALL pass: producers writing r7 in EX and MEM, consumer reads r7 -> fwd_sel=1 (youngest wins); write to r0 -> fwd_sel=0.
REQ-037 SHALL pass: load-use hazard and br_taken in same cycle -> flush=1, stall=0, flush_cnt=1, EX/MEM shadow entries cleared next edge.
REQ-038 SHALL pass: CNT_W=4, hold load-use stall 20 cycles -> stall_cnt reaches 15 and stays 15.
REQ-039 SHALL pass: reset asserted with three valid producers in flight -> next cycle all fwd_sel=0, counters 0.
